fixed_point_multiplier: RTL and testbench

FIXED_POINT_MULTIPLIER -- requirements
Module: fixed_point_multiplier

---
 rtl/fixed_point_multiplier.sv | 99 +++++++++
 tb/tb_fixed_point_multiplier.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_multiplier.sv
// Sequential UQ6.4 x UQ6.4 multiplier using shift-add, one multiplier bit per cycle.
// Optional build macro FIXED_POINT_MULTIPLIER_SATURATE_EN clamps p to 10'h3FF on overflow.
module fixed_point_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] A,
  input  logic [9:0] B,
  output logic       busy,
  output logic       done,
  output logic [9:0] p,
  output logic       ov
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ITER = 4'd9;

  state_t      state, state_nxt;
  logic [19:0] mcand;    // multiplicand, shifted left once per iteration
  logic [9:0]  mplier;   // multiplier, shifted right so bit 0 is the current bit
  logic [19:0] acc;
  logic [3:0]  cnt;

  logic [19:0] acc_add;
  logic        ov_nxt;
  logic [9:0]  p_nxt;

  // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == LAST_ITER) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The final iteration's sum feeds the result registers on the same edge that enters DONE.
  assign acc_add = acc + (mplier[0] ? mcand : 20'd0);
  assign ov_nxt  = |acc_add[19:14];

`ifdef FIXED_POINT_MULTIPLIER_SATURATE_EN
  assign p_nxt = ov_nxt ? 10'h3FF : acc_add[13:4];
`else
  assign p_nxt = acc_add[13:4];
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the operand and accumulator registers are small flops, not memories, so they are reset too.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      p      <= '0;
      ov     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {10'd0, A};
            mplier <= B;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          acc    <= acc_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == LAST_ITER) begin
            cnt <= '0;
            p   <= p_nxt;
            ov  <= ov_nxt;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Self-checking bench for fixed_point_multiplier: directed corner cases, random operands,
// start held high continuously, and reset abort. Reference is plain integer arithmetic.
module tb_fixed_point_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] A, B;
  logic       busy, done, ov;
  logic [9:0] p;

  int total = 0;
  int bad   = 0;

  fixed_point_multiplier dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .p     (p),
    .ov    (ov)
  );

  always #5 clk = ~clk;

  // Reference: exact product, truncated fraction, overflow when the integer part needs more than 6 bits.
  function automatic logic [10:0] model(input logic [9:0] a, input logic [9:0] b);
    int unsigned full;
    logic        m_ov;
    logic [9:0]  m_p;
    full = int'(a) * int'(b);
    m_ov = (full >= 16384);
    m_p  = 10'((full / 16) % 1024);
`ifdef FIXED_POINT_MULTIPLIER_SATURATE_EN
    if (m_ov) m_p = 10'h3FF;
`endif
    return {m_ov, m_p};
  endfunction

  // One complete operation: accept, scramble inputs, wait for done, check latency/result/pulse width.
  task automatic do_mul(input logic [9:0] a, input logic [9:0] b, input string name);
    logic [10:0] exp;
    int          lat;
    exp = model(a, b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = 10'($urandom);
    B = 10'($urandom);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL %s busy: got %b want 1 (cycle %0d)", name, busy, k);
      end
      if (done === 1'b1) begin
        lat = k + 1;  // edge at which done is first sampled high
        break;
      end
    end
    total++;
    if (lat != 11) begin
      bad++;
      $display("FAIL %s latency: got %0d edges want 11", name, lat);
    end
    total++;
    if ({ov, p} !== exp) begin
      bad++;
      $display("FAIL %s result: got ov=%b p=%h want ov=%b p=%h", name, ov, p, exp[10], exp[9:0]);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || {ov, p} !== exp) begin
      bad++;
      $display("FAIL %s after_done: got done=%b busy=%b ov=%b p=%h want 0 0 %b %h",
               name, done, busy, ov, p, exp[10], exp[9:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; A = 10'h3FF; B = 10'h3FF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 10'h000 || ov !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b p=%h ov=%b want 0 0 000 0", busy, done, p, ov);
    end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_directed();
    do_mul(10'h018, 10'h020, "1.5x2.0");
    do_mul(10'h3FF, 10'h3FF, "max_x_max");
    do_mul(10'h080, 10'h07F, "boundary_3f8");
    do_mul(10'h001, 10'h001, "truncate_lsb");
    do_mul(10'h081, 10'h07F, "full_16383");
    do_mul(10'h080, 10'h080, "full_16384");
    do_mul(10'h000, 10'h3FF, "zero_a");
    do_mul(10'h2A5, 10'h000, "zero_b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 15; i++)
      do_mul(10'($urandom), 10'($urandom), $sformatf("rand%0d", i));
  endtask

  // start held high for 30 cycles with fresh operands every cycle; expect acceptance every 12 cycles.
  task automatic test_back_to_back();
    int          last_acc = -100;
    int          acc_q[$];
    logic [10:0] exp_q[$];
    int          n_acc = 0;
    logic        exp_done;
    logic [10:0] e;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      exp_done = (acc_q.size() > 0) && (acc_q[0] == i - 11);
      total++;
      if (done !== exp_done) begin
        bad++;
        $display("FAIL b2b_done cycle %0d: got %b want %b", i, done, exp_done);
      end
      if (exp_done) begin
        e = exp_q.pop_front();
        void'(acc_q.pop_front());
        total++;
        if ({ov, p} !== e) begin
          bad++;
          $display("FAIL b2b_result cycle %0d: got ov=%b p=%h want ov=%b p=%h", i, ov, p, e[10], e[9:0]);
        end
      end
      start = (i < 30);
      A = 10'($urandom);
      B = 10'($urandom);
      if (start && (i - last_acc >= 12)) begin
        last_acc = i;
        n_acc++;
        acc_q.push_back(i);
        exp_q.push_back(model(A, B));
      end
    end
    start = 1'b0;
    total++;
    if (n_acc != 3 || acc_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: got accepted=%0d pending=%0d want 3 0", n_acc, acc_q.size());
    end
  endtask

  task automatic test_reset_abort();
    do_mul(10'h018, 10'h020, "pre_abort");
    @(negedge clk);
    A = 10'h3FF; B = 10'h3FF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || p !== 10'h000 || ov !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: got busy=%b done=%b p=%h ov=%b want 0 0 000 0", busy, done, p, ov);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL abort_quiet cycle %0d: got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    do_mul(10'($urandom), 10'($urandom), "post_abort");
  endtask

  initial begin
    start = 1'b0; A = '0; B = '0; rst = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
